// File: rtl/status_irq_register.sv
// Peripheral status register: ENA, live bits, W1C sticky flags, irq mask, registered read port and irq.
// Optional per-flag saturating event counters are built when STATUSREG_EVCOUNT_EN is defined.
module status_irq_register #(
  parameter int STICKY_W = 4,
  parameter int LIVE_W   = 3,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int CNT_W    = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         wr_en,
  input  logic                         rd_en,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DATA_W-1:0]            wr_data,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         rd_valid,
  input  logic [STICKY_W-1:0]          sticky_set,
  input  logic [LIVE_W-1:0]            live_in,
  output logic [LIVE_W+STICKY_W:0]     status_out,
  output logic                         irq
);

  localparam int SW         = 1 + LIVE_W + STICKY_W;
  localparam int STICKY_LSB = LIVE_W + 1;

  logic                  ena_reg;
  logic                  ena_next;
  logic [LIVE_W-1:0]     live_reg;
  logic [STICKY_W-1:0]   sticky_reg;
  logic [STICKY_W-1:0]   sticky_next;
  logic [STICKY_W-1:0]   sticky_clr;
  logic [STICKY_W-1:0]   set_acc;
  logic [SW-1:0]         mask_reg;
  logic [SW-1:0]         status_word;
  logic                  irq_next;
  logic                  wr_status;
  logic                  wr_mask;
  logic [DATA_W-1:0]     rd_mux;

  assign wr_status = wr_en && (addr == ADDR_W'(0));
  assign wr_mask   = wr_en && (addr == ADDR_W'(1));

  // Events are only accepted once ENA is already set, so the cycle that
  // writes ENA=1 still drops them.
  assign set_acc  = ena_reg ? sticky_set : '0;
  assign ena_next = wr_status ? wr_data[0] : ena_reg;

  genvar gi;
  generate
    for (gi = 0; gi < STICKY_W; gi++) begin : g_flag
      // Writing ENA=0 wipes every flag; otherwise a 1 in the flag's position clears it.
      assign sticky_clr[gi]  = wr_status && (!wr_data[0] || wr_data[STICKY_LSB+gi]);
      // Set wins over clear so that a coincident event is never lost.
      assign sticky_next[gi] = set_acc[gi] || (sticky_reg[gi] && !sticky_clr[gi]);
    end
  endgenerate

  assign status_word = {sticky_reg, live_reg, ena_reg};
  assign status_out  = status_word;
  assign irq_next    = ena_reg && (|(status_word[SW-1:1] & mask_reg[SW-1:1]));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ena_reg    <= 1'b0;
      live_reg   <= '0;
      sticky_reg <= '0;
      mask_reg   <= '0;
      irq        <= 1'b0;
    end else begin
      ena_reg    <= ena_next;
      live_reg   <= live_in;
      sticky_reg <= sticky_next;
      irq        <= irq_next;
      if (wr_mask) begin
        mask_reg <= wr_data[SW-1:0];
      end
    end
  end

`ifdef STATUSREG_EVCOUNT_EN
  logic [STICKY_W*CNT_W-1:0] cnt_flat;

  generate
    for (gi = 0; gi < STICKY_W; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_reg <= '0;
        end else if (sticky_clr[gi]) begin
          // A clear that coincides with an event restarts the count at that event.
          cnt_reg <= set_acc[gi] ? CNT_W'(1) : '0;
        end else if (set_acc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end

      assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_reg;
    end
  endgenerate
`endif

  always_comb begin
    rd_mux = '0;
    if (addr == ADDR_W'(0)) begin
      rd_mux = DATA_W'(status_word);
    end else if (addr == ADDR_W'(1)) begin
      rd_mux = DATA_W'(mask_reg);
    end
`ifdef STATUSREG_EVCOUNT_EN
    else begin
      for (int i = 0; i < STICKY_W; i++) begin
        if (addr == ADDR_W'(i + 2)) begin
          rd_mux = DATA_W'(cnt_flat[i*CNT_W +: CNT_W]);
        end
      end
    end
`endif
  end

  // Read samples the pre-edge contents, so a same-cycle write is not visible yet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_status_irq_register.sv
// Self-checking bench for status_irq_register; read results are scoreboarded through a queue.
// Counter checks follow STATUSREG_EVCOUNT_EN.
module tb_status_irq_register;

  logic       clk;
  logic       reset_n;
  logic       wr_en;
  logic       rd_en;
  logic [3:0] addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [3:0] sticky_set;
  logic [2:0] live_in;
  logic [7:0] status_out;
  logic       irq;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  status_irq_register dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .addr       (addr),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .sticky_set (sticky_set),
    .live_in    (live_in),
    .status_out (status_out),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %-12s got 0x%0h exp 0x%0h ok", tag, got, exp);
    end else begin
      $display("FAIL %-12s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    addr    = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, input logic [7:0] e);
    rd_en = 1'b1;
    addr  = a;
    exp_q.push_back(e);
    tick();
    rd_en = 1'b0;
  endtask

  // Scoreboard: every rd_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        check("rd_unexp", 32'(rd_valid), 32'h0);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("rd_data", 32'(rd_data), 32'(e));
      end
    end
  end

  initial begin
    reset_n    = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    addr       = '0;
    wr_data    = '0;
    sticky_set = '0;
    live_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_status", 32'(status_out), 32'h0);
    check("rst_irq",    32'(irq),        32'h0);
    check("rst_rdval",  32'(rd_valid),   32'h0);
    check("rst_rddata", 32'(rd_data),    32'h0);
    reset_n = 1'b1;
    tick();

    // Set and partial W1C
    do_write(4'd0, 8'h01);
    check("ena_on", 32'(status_out), 32'h01);
    sticky_set = 4'b0101;
    tick();
    sticky_set = '0;
    check("set_0101", 32'(status_out), 32'h51);
    do_write(4'd0, 8'h11);
    check("w1c_bit4", 32'(status_out), 32'h41);
    do_read(4'd0, 8'h41);

    // Live bits, then read and write in the same cycle
    live_in = 3'b101;
    tick();
    check("live_101", 32'(status_out), 32'h4B);
    rd_en   = 1'b1;
    wr_en   = 1'b1;
    addr    = 4'd0;
    wr_data = 8'h41;
    exp_q.push_back(8'h4B);
    tick();
    rd_en = 1'b0;
    wr_en = 1'b0;
    check("w1c_bit6", 32'(status_out), 32'h0B);
    live_in = 3'b000;
    tick();
    check("live_000", 32'(status_out), 32'h01);

    // Set/clear race on flag 0
    sticky_set = 4'b0001;
    wr_en      = 1'b1;
    addr       = 4'd0;
    wr_data    = 8'h11;
    tick();
    wr_en      = 1'b0;
    sticky_set = '0;
    check("race", 32'(status_out), 32'h11);

    // Disable clears flags and blocks events
    sticky_set = 4'hF;
    tick();
    sticky_set = '0;
    check("set_all", 32'(status_out), 32'hF1);
    do_write(4'd0, 8'h00);
    check("disable", 32'(status_out), 32'h00);
    sticky_set = 4'hF;
    tick();
    check("set_ena0", 32'(status_out), 32'h00);
    wr_en   = 1'b1;
    addr    = 4'd0;
    wr_data = 8'h01;
    tick();
    wr_en      = 1'b0;
    sticky_set = '0;
    check("set_enawr", 32'(status_out), 32'h01);

    // IRQ path
    do_write(4'd1, 8'h80);
    do_read(4'd1, 8'h80);
    sticky_set = 4'b1000;
    tick();
    sticky_set = '0;
    check("set_bit7", 32'(status_out), 32'h81);
    check("irq_lat0", 32'(irq), 32'h0);
    tick();
    check("irq_on", 32'(irq), 32'h1);
    do_write(4'd0, 8'h81);
    check("clr_bit7", 32'(status_out), 32'h01);
    check("irq_hold", 32'(irq), 32'h1);
    tick();
    check("irq_off", 32'(irq), 32'h0);
    sticky_set = 4'b0100;
    tick();
    sticky_set = '0;
    tick();
    check("irq_unmask", 32'(irq), 32'h0);

    // Unmapped address: writes ignored, reads zero
    do_write(4'd9, 8'hFF);
    check("wr_unmap", 32'(status_out), 32'h41);
    do_read(4'd1, 8'h80);
    do_read(4'd9, 8'h00);

`ifdef STATUSREG_EVCOUNT_EN
    sticky_set = 4'b0010;
    repeat (300) tick();
    sticky_set = '0;
    check("cnt_flag", 32'(status_out), 32'h61);
    do_read(4'd3, 8'hFF);
    do_write(4'd0, 8'h21);
    check("cnt_w1c", 32'(status_out), 32'h41);
    do_read(4'd3, 8'h00);
    sticky_set = 4'b0010;
    wr_en      = 1'b1;
    addr       = 4'd0;
    wr_data    = 8'h21;
    tick();
    wr_en      = 1'b0;
    sticky_set = '0;
    do_read(4'd3, 8'h01);
    do_read(4'd2, 8'h00);
`else
    do_read(4'd3, 8'h00);
    do_read(4'd2, 8'h00);
`endif

    // Asynchronous reset in the middle of a read with irq asserted
    do_write(4'd1, 8'h40);
    tick();
    check("irq_pre_rst", 32'(irq), 32'h1);
    rd_en = 1'b1;
    addr  = 4'd0;
    sticky_set = 4'hF;
    tick();
    reset_n = 1'b0;
    #1;
    check("arst_status", 32'(status_out), 32'h0);
    check("arst_irq",    32'(irq),        32'h0);
    check("arst_rdval",  32'(rd_valid),   32'h0);
    check("arst_rddata", 32'(rd_data),    32'h0);
    rd_en      = 1'b0;
    sticky_set = '0;
    tick();
    reset_n = 1'b1;
    tick();
    do_read(4'd1, 8'h00);
    tick();
    check("q_empty", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
